// File: rtl/block_pkg.sv
// Shared types and constants for the begin/end block-check stream.
package block_pkg;

    typedef enum logic [1:0] {
        CMD_BEGIN = 2'b00,
        CMD_END   = 2'b01,
        CMD_DECOY = 2'b10,
        CMD_GAP   = 2'b11
    } cmd_e;

    // Lowercase ASCII; uppercase is derived by clearing CASE_BIT.
    localparam logic [7:0] CH_SPACE = 8'd32;
    localparam logic [7:0] CH_B     = 8'd98;
    localparam logic [7:0] CH_E     = 8'd101;
    localparam logic [7:0] CH_G     = 8'd103;
    localparam logic [7:0] CH_I     = 8'd105;
    localparam logic [7:0] CH_N     = 8'd110;
    localparam logic [7:0] CH_D     = 8'd100;
    localparam logic [7:0] CH_S     = 8'd115;
    localparam logic [7:0] CASE_BIT = 8'h20;

    // Token lengths, trailing space included.
    localparam logic [3:0] LEN_BEGIN = 4'd6;
    localparam logic [3:0] LEN_END   = 4'd4;
    localparam logic [3:0] LEN_DECOY = 4'd5;
    localparam logic [3:0] LEN_GAP   = 4'd1;

    // Index of the final character (the space) of a token.
    function automatic logic [2:0] tok_last(cmd_e t);
        logic [3:0] len;
        case (t)
            CMD_BEGIN: len = LEN_BEGIN;
            CMD_END:   len = LEN_END;
            CMD_DECOY: len = LEN_DECOY;
            default:   len = LEN_GAP;
        endcase
        return 3'(len - 4'd1);
    endfunction

endpackage

// File: rtl/block_token_rom.sv
// Character lookup: (token, index, case) -> ASCII byte.
module block_token_rom
    import block_pkg::*;
(
    input  cmd_e       tok,
    input  logic [2:0] idx,
    input  logic       upper,
    output logic [7:0] ch
);

    logic [7:0] base;

    // Select the lowercase character, then fold case on letters only.
    always_comb begin
        base = CH_SPACE;
        case (tok)
            CMD_BEGIN: case (idx)
                3'd0:    base = CH_B;
                3'd1:    base = CH_E;
                3'd2:    base = CH_G;
                3'd3:    base = CH_I;
                3'd4:    base = CH_N;
                default: base = CH_SPACE;
            endcase
            CMD_END, CMD_DECOY: case (idx)
                3'd0:    base = CH_E;
                3'd1:    base = CH_N;
                3'd2:    base = CH_D;
                3'd3:    base = (tok == CMD_DECOY) ? CH_S : CH_SPACE;
                default: base = CH_SPACE;
            endcase
            default: base = CH_SPACE;
        endcase
        ch = (upper && base != CH_SPACE) ? (base & ~CASE_BIT) : base;
    end

endmodule

// File: rtl/block_stream_gen.sv
// Serializes begin/end/decoy/gap commands to ASCII and tracks nesting balance.
module block_stream_gen
    import block_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic               cmd_upper,
    output logic               cmd_ready,
    output logic [7:0]         out,
    output logic               out_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               underflow,
    output logic               overflow,
    output logic               balanced
);

    typedef enum logic {IDLE, EMIT} state_e;

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = {DEPTH_W{1'b1}};

    state_e     state;
    cmd_e       tok;
    logic [2:0] idx;
    logic       upper;
    logic       last;
    logic       accept;
    logic [7:0] ch;
    cmd_e       cmd_t;

    assign cmd_t     = cmd_e'(cmd);
    assign last      = (idx == tok_last(tok));
    assign cmd_ready = (state == IDLE) || (state == EMIT && last);
    assign accept    = cmd_valid && cmd_ready;
    assign out_valid = (state == EMIT);
    assign out       = out_valid ? ch : 8'd0;
    assign balanced  = (depth == '0) && !underflow && !overflow;

    block_token_rom u_rom (
        .tok   (tok),
        .idx   (idx),
        .upper (upper),
        .ch    (ch)
    );

    // Emission FSM: load on accept, step idx, chain the next token with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tok   <= CMD_GAP;
            idx   <= 3'd0;
            upper <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= EMIT;
                    tok   <= cmd_t;
                    upper <= cmd_upper;
                    idx   <= 3'd0;
                end
                EMIT: if (last) begin
                    if (accept) begin
                        tok   <= cmd_t;
                        upper <= cmd_upper;
                        idx   <= 3'd0;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    idx <= idx + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Nesting depth and sticky error flags change at acceptance, not emission.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth     <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            if (cmd_t == CMD_BEGIN) begin
                if (depth == MAX_DEPTH) overflow <= 1'b1;
                else                    depth    <= depth + 1'b1;
            end else if (cmd_t == CMD_END) begin
                if (depth == '0) underflow <= 1'b1;
                else             depth     <= depth - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_block_stream_gen.sv
// Scoreboard bench for block_stream_gen.
module tb_block_stream_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_upper = 1'b0;
    logic       cmd_ready;
    logic [7:0] out;
    logic       out_valid;
    logic [7:0] depth;
    logic       underflow, overflow, balanced;

    // Small-depth instance for saturation checks.
    logic       cv2 = 1'b0;
    logic [1:0] cmd2 = 2'b00;
    logic       ready2, ov2, un2, bal2, vld2;
    logic [7:0] out2;
    logic [1:0] depth2;

    int n_tests = 0;
    int n_fail  = 0;
    int run = 0, maxrun = 0;
    logic [7:0] exp_q[$];
    int md = 0;
    bit mu = 0, mo = 0;

    block_stream_gen #(.DEPTH_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_upper(cmd_upper), .cmd_ready(cmd_ready), .out(out),
        .out_valid(out_valid), .depth(depth), .underflow(underflow),
        .overflow(overflow), .balanced(balanced)
    );

    block_stream_gen #(.DEPTH_W(2)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cv2), .cmd(cmd2),
        .cmd_upper(1'b0), .cmd_ready(ready2), .out(out2),
        .out_valid(vld2), .depth(depth2), .underflow(un2),
        .overflow(ov2), .balanced(bal2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: every valid byte must match the scoreboard head.
    always @(negedge clk) begin
        if (out_valid) begin
            run++;
            if (run > maxrun) maxrun = run;
            if (exp_q.size() == 0) chk("extra_char", out_valid, 0);
            else chk("char", out, exp_q.pop_front());
        end else begin
            run = 0;
            chk("idle_out_zero", out, 0);
        end
    end

    task automatic push_tok(input logic [1:0] c, input logic u);
        string s;
        logic [7:0] b;
        case (c)
            2'd0: s = "begin ";
            2'd1: s = "end ";
            2'd2: s = "ends ";
            default: s = " ";
        endcase
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            if (u && b != 8'd32) b = b - 8'd32;
            exp_q.push_back(b);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_depth"}, depth, md);
        chk({tag, "_under"}, underflow, mu);
        chk({tag, "_over"}, overflow, mo);
        chk({tag, "_bal"}, balanced, (md == 0 && !mu && !mo));
    endtask

    // Present a command at a negedge, wait for ready, return after acceptance.
    task automatic send(input logic [1:0] c, input logic u);
        int t = 0;
        cmd_valid = 1'b1; cmd = c; cmd_upper = u;
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        if (!cmd_ready) begin
            chk("ready_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        push_tok(c, u);
        if (c == 2'd0) begin if (md == 255) mo = 1; else md++; end
        else if (c == 2'd1) begin if (md == 0) mu = 1; else md--; end
        @(posedge clk);
        @(negedge clk);
        chk_state("accept");
    endtask

    task automatic drain();
        int t = 0;
        cmd_valid = 1'b0;
        #1;
        while ((exp_q.size() != 0 || out_valid) && t < 60) begin
            @(negedge clk); #1; t++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; cv2 = 1'b0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        exp_q.delete();
        md = 0; mu = 0; mo = 0;
        chk("rst_vld", out_valid, 0);
        chk("rst_out", out, 0);
        chk_state("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
    endtask

    initial begin
        // 1: single lowercase BEGIN
        do_reset();
        send(2'd0, 1'b0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t1_ready_lo", cmd_ready, 0);
            @(negedge clk);
        end
        chk("t1_ready_hi", cmd_ready, 1);
        drain();
        chk_state("t1");

        // 2: BEGIN upper then END lower, back to back
        do_reset();
        maxrun = 0;
        send(2'd0, 1'b1);
        send(2'd1, 1'b0);
        drain();
        chk("t2_nobubble", maxrun, 10);
        chk_state("t2");

        // 3: END at depth 0, then a pair: underflow sticks
        do_reset();
        send(2'd1, 1'b0);
        drain();
        chk_state("t3a");
        send(2'd0, 1'b0);
        send(2'd1, 1'b0);
        drain();
        chk_state("t3b");

        // 4: BEGIN DECOY GAP END
        do_reset();
        send(2'd0, 1'b0);
        send(2'd2, 1'b0);
        send(2'd3, 1'b0);
        send(2'd1, 1'b0);
        drain();
        chk_state("t4");

        // 5: saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            cv2 = 1'b1; cmd2 = 2'd0;
            while (!ready2 && t < 100) begin @(negedge clk); t++; end
            @(posedge clk); @(negedge clk);
            cv2 = 1'b0;
            if (k == 2) begin
                chk("t5_depth3", depth2, 3);
                chk("t5_over_pre", ov2, 0);
            end
        end
        chk("t5_depth", depth2, 3);
        chk("t5_over", ov2, 1);
        chk("t5_bal", bal2, 0);

        // 6: reset during the third character of BEGIN
        do_reset();
        send(2'd0, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t6_vld", out_valid, 0);
        chk("t6_out", out, 0);
        chk("t6_depth", depth, 0);
        chk("t6_bal", balanced, 1);
        exp_q.delete();
        md = 0; mu = 0; mo = 0;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("t6_ready", cmd_ready, 1);
        @(negedge clk);
        send(2'd1, 1'b0);
        drain();
        chk_state("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
